// File: rtl/rx_frame_ctrl.sv
// Collects SOF-delimited UART payload bytes into a display frame and commits it atomically.
// Partial frames are dropped on a receive-error edge or an inter-byte timeout.
module rx_frame_ctrl #(
    parameter int         N_CHARS        = 4,
    parameter logic [7:0] SOF_BYTE       = 8'hAA,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           Rx_DATA,
    input  logic                 Rx_VALID,
    input  logic                 Rx_PERROR,
    input  logic                 Rx_FERROR,
    output logic [8*N_CHARS-1:0] disp_data,
    output logic                 disp_update,
    output logic                 frame_drop,
    output logic                 busy,
    output logic [7:0]           err_count,
    output logic [1:0]           dbg_state
);
    localparam int IW = (N_CHARS > 2) ? $clog2(N_CHARS) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BW = $clog2(8 * N_CHARS);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_CHARS - 1);
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [IW-1:0]          idx_q;
    logic [TW-1:0]          timer_q;
    logic [8*N_CHARS-1:0]   buf_q;
    logic [8*N_CHARS-1:0]   disp_q;
    logic                   disp_update_q;
    logic                   frame_drop_q;
    logic                   busy_q;
    logic                   err_lvl_q;
    logic [7:0]             err_cnt_q;

    logic                   err_lvl_d;
    logic                   err_evt;
    logic [7:0]             err_cnt_d;
    logic [BW-1:0]          slot;

    assign err_lvl_d = Rx_PERROR | Rx_FERROR;
    assign err_evt   = err_lvl_d & ~err_lvl_q;
    assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    // Char 0 lands in the most significant byte of the frame.
    assign slot      = BW'((N_CHARS - 1 - int'(idx_q)) * 8);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            buf_q         <= '0;
            disp_q        <= '0;
            disp_update_q <= 1'b0;
            frame_drop_q  <= 1'b0;
            busy_q        <= 1'b0;
            err_lvl_q     <= 1'b0;
            err_cnt_q     <= 8'd0;
        end else begin
            err_lvl_q     <= err_lvl_d;
            disp_update_q <= 1'b0;
            frame_drop_q  <= 1'b0;
            if (err_evt) begin
                err_cnt_q <= err_cnt_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (Rx_VALID && (Rx_DATA == SOF_BYTE)) begin
                        state_q <= S_COLLECT;
                        idx_q   <= '0;
                        timer_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    // An error edge wins over a byte arriving in the same cycle.
                    if (err_evt) begin
                        state_q      <= S_IDLE;
                        frame_drop_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else if (Rx_VALID) begin
                        timer_q <= '0;
                        if (Rx_DATA == SOF_BYTE) begin
                            idx_q <= '0;
                        end else begin
                            buf_q[slot +: 8] <= Rx_DATA;
                            idx_q            <= idx_q + IW'(1);
                            if (idx_q == LAST_IDX) begin
                                state_q <= S_COMMIT;
                            end
                        end
                    end else if (timer_q == TMAX) begin
                        state_q      <= S_IDLE;
                        frame_drop_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_COMMIT: begin
                    disp_q        <= buf_q;
                    disp_update_q <= 1'b1;
                    state_q       <= S_IDLE;
                    busy_q        <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign disp_data   = disp_q;
    assign disp_update = disp_update_q;
    assign frame_drop  = frame_drop_q;
    assign busy        = busy_q;
    assign err_count   = err_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: directed frames plus random traffic, with frame events
// predicted by a byte-list reference model and checked by a separate monitor.
module tb_rx_frame_ctrl;
    localparam int         N   = 4;
    localparam int         T   = 16;
    localparam logic [7:0] SOF = 8'hAA;
    localparam int         DW  = 8 * N;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    Rx_DATA;
    logic          Rx_VALID;
    logic          Rx_PERROR;
    logic          Rx_FERROR;
    logic [DW-1:0] disp_data;
    logic          disp_update;
    logic          frame_drop;
    logic          busy;
    logic [7:0]    err_count;
    logic [1:0]    dbg_state;

    rx_frame_ctrl #(.N_CHARS(N), .SOF_BYTE(SOF), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID),
        .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR), .disp_data(disp_data),
        .disp_update(disp_update), .frame_drop(frame_drop), .busy(busy),
        .err_count(err_count), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: event = {is_drop, frame}, plus the cycle it must appear on
    logic [DW:0] exp_q[$];
    int          exp_cyc_q[$];

    // Reference model: a list of payload bytes and a silence counter
    bit            m_active;
    bit            m_commit;
    logic [7:0]    m_bytes[$];
    int            m_silent;
    bit            m_err_prev;
    int            m_errs;
    logic [DW-1:0] m_disp;

    task automatic model_reset();
        m_active   = 0;
        m_commit   = 0;
        m_bytes.delete();
        m_silent   = 0;
        m_err_prev = 0;
        m_errs     = 0;
        m_disp     = '0;
    endtask

    task automatic push_evt(input bit is_drop, input logic [DW-1:0] frame);
        exp_q.push_back({is_drop, frame});
        exp_cyc_q.push_back(cyc + 1);
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic lvl);
        bit ev;
        logic [DW-1:0] w;
        ev = lvl && !m_err_prev;
        m_err_prev = lvl;
        if (ev && m_errs < 255) m_errs++;
        if (m_commit) begin
            w = '0;
            foreach (m_bytes[i]) w = {w[DW-9:0], m_bytes[i]};
            m_disp = w;
            push_evt(1'b0, w);
            m_commit = 0;
        end else if (m_active) begin
            if (ev) begin
                push_evt(1'b1, '0);
                m_active = 0;
            end else if (v) begin
                m_silent = 0;
                if (d == SOF) begin
                    m_bytes.delete();
                end else begin
                    m_bytes.push_back(d);
                    if (m_bytes.size() == N) begin
                        m_active = 0;
                        m_commit = 1;
                    end
                end
            end else begin
                m_silent++;
                if (m_silent == T) begin
                    push_evt(1'b1, '0);
                    m_active = 0;
                end
            end
        end else if (v && d == SOF) begin
            m_active = 1;
            m_bytes.delete();
            m_silent = 0;
        end
    endtask

    // Driver: one call per clock cycle
    task automatic drive(input logic v, input logic [7:0] d, input logic pe, input logic fe);
        Rx_VALID  = v;
        Rx_DATA   = d;
        Rx_PERROR = pe;
        Rx_FERROR = fe;
        model_step(v, d, pe | fe);
        @(posedge clk);
        #1;
        chk("busy", busy, m_active || m_commit);
        chk("err_count", err_count, m_errs);
        chk("disp_data", disp_data, m_disp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_disp_data"}, disp_data, 0);
        chk({tag, "_disp_update"}, disp_update, 0);
        chk({tag, "_frame_drop"}, frame_drop, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err_count"}, err_count, 0);
    endtask

    task automatic mid_reset();
        reset = 1'b1;
        #2;
        check_zero_outputs("mid_reset");
        Rx_VALID  = 1'b0;
        Rx_DATA   = 8'h00;
        Rx_PERROR = 1'b0;
        Rx_FERROR = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: pops an expected event whenever the DUT pulses one
    logic [DW:0] mon_got;
    logic [DW:0] mon_exp;
    int          mon_cyc;
    always @(negedge clk) begin
        if (!reset && (disp_update || frame_drop)) begin
            chk("drop_update_overlap", disp_update & frame_drop, 0);
            mon_got = {frame_drop, disp_update ? disp_data : {DW{1'b0}}};
            chk("event_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                chk("event", mon_got, mon_exp);
                chk("event_cycle", cyc, mon_cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic       r_v;
    logic [7:0] r_d;
    logic       r_lvl;
    int         r_pct;

    initial begin
        reset     = 1'b1;
        Rx_VALID  = 1'b0;
        Rx_DATA   = 8'h00;
        Rx_PERROR = 1'b0;
        Rx_FERROR = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b0;

        // Basic frame
        send(SOF); send(8'h41); send(8'h42); send(8'h43); send(8'h44);
        idle(2);
        chk("t1_disp", disp_data, 32'h41424344);

        // Error mid-frame, then a clean frame
        send(SOF); send(8'h41); send(8'h42);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);
        chk("t2_err_count", err_count, 8'd1);
        chk("t2_disp_kept", disp_data, 32'h41424344);
        send(SOF); send(8'h31); send(8'h32); send(8'h33); send(8'h34);
        idle(2);
        chk("t2_disp", disp_data, 32'h31323334);

        // Inter-byte timeout
        send(SOF); send(8'h41);
        idle(T + 4);
        chk("t3_idle", busy, 0);

        // Resync on a second SOF
        send(SOF); send(8'h41); send(SOF);
        send(8'h51); send(8'h52); send(8'h53); send(8'h54);
        idle(2);
        chk("t4_disp", disp_data, 32'h51525354);

        // Error edge and byte in the same cycle: byte discarded
        send(SOF); send(8'h41);
        drive(1'b1, 8'h42, 1'b1, 1'b0);
        idle(2);
        send(SOF); send(8'h61); send(8'h62); send(8'h63); send(8'h64);
        idle(2);

        // Bytes during COMMIT are ignored, error during COMMIT still counts
        send(SOF); send(8'h71); send(8'h72); send(8'h73);
        drive(1'b1, 8'h74, 1'b0, 1'b0);
        drive(1'b1, SOF, 1'b0, 1'b1);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(2);
        chk("commit_ignores_sof", disp_data, 32'h71727374);

        // Error counter saturation
        for (int i = 0; i < 300; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            drive(1'b0, 8'h00, 1'b0, 1'b1);
        end
        idle(1);
        chk("err_saturated", err_count, 8'd255);

        // Bytes without SOF are ignored; reset mid-frame clears everything
        send(8'h41); send(8'h42);
        chk("no_sof_idle", busy, 0);
        send(SOF); send(8'h41);
        mid_reset();
        idle(2);

        // Random traffic
        r_lvl = 1'b0;
        for (int b = 0; b < 40; b++) begin
            r_pct = (b % 3 == 0) ? 4 : ((b % 3 == 1) ? 30 : 70);
            for (int k = 0; k < 80; k++) begin
                r_v = ($urandom_range(0, 99) < r_pct);
                r_d = ($urandom_range(0, 3) == 0) ? SOF : 8'($urandom_range(0, 255));
                if ($urandom_range(0, 49) == 0) r_lvl = ~r_lvl;
                drive(r_v, r_d, r_lvl & b[0], r_lvl & ~b[0]);
            end
        end
        idle(T + 4);
        chk("leftover_events", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
